// File: rtl/i2s_pkg.sv
// Shared widths, framing constants and the FIFO-entry to frame packing for the I2S serializer.
package i2s_pkg;

   localparam int CNT_W    = 10;
   localparam int SLOT_W   = 6;
   localparam int SAMPLE_W = 16;
   localparam int FRAME_W  = 64;
   localparam int ENTRY_W  = 2 * SAMPLE_W;

   localparam logic [SLOT_W-1:0] LR_SPLIT = 6'd32;

   // Entry {L, R} becomes {L, pad, R, pad} so each channel sits MSB-aligned in a 32-bit half.
   function automatic logic [FRAME_W-1:0] pack_frame(input logic [ENTRY_W-1:0] entry);
      return {entry[ENTRY_W-1 -: SAMPLE_W], {SAMPLE_W{1'b0}},
              entry[SAMPLE_W-1:0], {SAMPLE_W{1'b0}}};
   endfunction

endpackage

// File: rtl/i2s_fifo.sv
// Synchronous FIFO of stereo {L, R} entries; wrap bit on each pointer separates full from empty.
module i2s_fifo
   import i2s_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] head,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: free-running divider drives all pins; frames load from the FIFO at cnt == 1023.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic signed [SAMPLE_W-1:0] sample_l,
   input  logic signed [SAMPLE_W-1:0] sample_r,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   output logic                       I2S_MCLK,
   output logic                       I2S_SCLK,
   output logic                       I2S_LRCLK,
   output logic                       I2S_SDIN,
   output logic                       underrun
);

   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-1:0] frame_p0;
   logic               lrclk_p1;
   logic               sdin_p1;
   logic [ENTRY_W-1:0] head;
   logic               full;
   logic               empty;
   logic               boundary;
   logic               sclk_fall;
   logic [SLOT_W-1:0]  slot_nxt;

   // Slot s carries frame bit (64 - s); slot 0 is the 1-SCLK I2S delay and is always 0.
   function automatic logic frame_bit(input logic [FRAME_W-1:0] f, input logic [SLOT_W-1:0] s);
      logic [SLOT_W-1:0] idx;
      idx = '0 - s;
      return (s == '0) ? 1'b0 : f[idx];
   endfunction

   assign boundary     = &cnt;
   assign sclk_fall    = &cnt[3:0];
   assign slot_nxt     = cnt[CNT_W-1 -: SLOT_W] + 1'b1;
   assign sample_ready = !full;
   assign underrun     = boundary && empty;
   assign I2S_MCLK     = cnt[1];
   assign I2S_SCLK     = cnt[3];
   assign I2S_LRCLK    = lrclk_p1;
   assign I2S_SDIN     = sdin_p1;

   i2s_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (sample_valid && sample_ready),
      .pop     (boundary),
      .wr_data ({sample_l, sample_r}),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   // p0: frame register loads at the boundary; p1: pins update on the SCLK falling edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         frame_p0 <= '0;
         lrclk_p1 <= 1'b0;
         sdin_p1  <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         if (boundary) frame_p0 <= empty ? '0 : pack_frame(head);
         if (sclk_fall) begin
            lrclk_p1 <= (slot_nxt >= LR_SPLIT);
            sdin_p1  <= frame_bit(frame_p0, slot_nxt);
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized scoreboard bench for i2s_tx: a frame-level model predicts every pin each cycle.
module tb_i2s_tx;

   localparam int DEPTH = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic signed [15:0] sample_l = '0;
   logic signed [15:0] sample_r = '0;
   logic               sample_valid = 1'b0;
   logic               sample_ready;
   logic               I2S_MCLK;
   logic               I2S_SCLK;
   logic               I2S_LRCLK;
   logic               I2S_SDIN;
   logic               underrun;

   always #5 CLK = ~CLK;

   i2s_tx #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .I2S_MCLK     (I2S_MCLK),
      .I2S_SCLK     (I2S_SCLK),
      .I2S_LRCLK    (I2S_LRCLK),
      .I2S_SDIN     (I2S_SDIN),
      .underrun     (underrun)
   );

   int          checks = 0;
   int          errors = 0;
   int          tcnt = 0;
   bit          started = 1'b0;
   bit          full_exp = 1'b0;
   bit          last_acc = 1'b0;
   logic [31:0] q [$];
   logic [15:0] cur_l = '0;
   logic [15:0] cur_r = '0;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s t=%0t cnt=%0d got %b expected %b", name, $time, tcnt, act, exp);
      end
   endtask

   function automatic logic exp_sdin(input int s, input logic [15:0] l, input logic [15:0] r);
      if (s >= 1 && s <= 16)  return l[16 - s];
      if (s >= 33 && s <= 48) return r[48 - s];
      return 1'b0;
   endfunction

   // Stimulus side: accepted frames go into the expected-frame queue.
   always @(posedge CLK) begin
      if (RST) begin
         started  = 1'b1;
         tcnt     = 0;
         last_acc = 1'b0;
         q.delete();
         cur_l = '0;
         cur_r = '0;
      end else begin
         last_acc = sample_valid && !full_exp;
         if (last_acc) q.push_back({sample_l, sample_r});
         tcnt = (tcnt + 1) % 1024;
      end
   end

   // Monitor: compare every pin, pop the next expected frame at each boundary.
   always @(negedge CLK) begin : mon
      int s;
      if (started) begin
         s = tcnt / 16;
         check1("mclk",     I2S_MCLK,     ((tcnt / 2) % 2) == 1);
         check1("sclk",     I2S_SCLK,     ((tcnt / 8) % 2) == 1);
         check1("lrclk",    I2S_LRCLK,    s >= 32);
         check1("sdin",     I2S_SDIN,     exp_sdin(s, cur_l, cur_r));
         check1("underrun", underrun,     (tcnt == 1023) && (q.size() == 0));
         check1("ready",    sample_ready, q.size() < DEPTH);
         full_exp = (q.size() >= DEPTH);
         if (tcnt == 1023) begin
            if (q.size() > 0) {cur_l, cur_r} = q.pop_front();
            else {cur_l, cur_r} = 32'h0;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wait_cnt(input int n);
      int k;
      k = 0;
      while (tcnt != n && k < 2048) begin
         step();
         k++;
      end
      if (tcnt != n) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt got %0d expected %0d", tcnt, n);
      end
   endtask

   task automatic push_one(input logic [15:0] l, input logic [15:0] r);
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      idle(3);
      RST = 1'b0;

      // idle: clock ratios and an underrun every frame
      idle(4096);

      // single known frame
      wait_cnt(10);
      push_one(16'hA5C3, 16'h8001);
      idle(2100);

      // backpressure with incrementing data
      sample_l = 16'h1000;
      sample_r = 16'hF000;
      sample_valid = 1'b1;
      for (int i = 0; i < 7168; i++) begin
         step();
         if (last_acc) begin
            sample_l = sample_l + 16'sd1;
            sample_r = sample_r - 16'sd1;
         end
      end
      sample_valid = 1'b0;
      idle(5200);

      // underrun recovery
      wait_cnt(100);
      push_one(16'($urandom), 16'($urandom));
      idle(4096);

      // push in the boundary cycle with the FIFO empty
      wait_cnt(1023);
      push_one(16'h7FFF, 16'h8000);
      idle(2200);

      // random traffic
      for (int i = 0; i < 10240; i++) begin
         sample_valid = ($urandom_range(0, 999) < 3);
         sample_l     = 16'($urandom);
         sample_r     = 16'($urandom);
         step();
      end
      sample_valid = 1'b0;
      idle(5200);

      // reset mid-frame with three frames buffered
      wait_cnt(5);
      for (int i = 0; i < 3; i++) push_one(16'($urandom), 16'($urandom));
      wait_cnt(320);
      RST = 1'b1;
      step();
      RST = 1'b0;
      idle(2100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
